// File: rtl/serial_adder.sv
// serial_adder: bit-serial two's-complement adder/subtractor.
// One full-adder slice plus a carry flip-flop produces one sum bit per clock,
// LSB first. Operands are captured on start; the result is held in an output
// register and only updated when an operation completes.
// Optional build macro SERIAL_ADDER_OVF_EN adds a registered signed-overflow
// output (ovf). With the macro undefined the port and its logic are absent.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Bit counter width: clog2(WIDTH), never less than one bit.
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic [WIDTH-1:0] s_sh_next;
    logic [CW-1:0]    count;
    logic             carry;
    logic             carry_next;
    logic             bit_s;
    logic             last;
    logic             load;

    // Full-adder slice on the current LSBs and the serial sum shift path.
    // The shift is written as a loop so WIDTH=1 needs no special-case slicing.
    always_comb begin
        bit_s      = a_sh[0] ^ b_sh[0] ^ carry;
        carry_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        s_sh_next  = '0;
        for (int unsigned i = 0; i + 1 < WIDTH; i++) begin
            s_sh_next[i] = s_sh[i+1];
        end
        s_sh_next[WIDTH-1] = bit_s;
        last = (count == CW'(WIDTH - 1));
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: operand capture, serial shifting and result register.
    // Subtraction is a + ~b + 1: b is inverted at capture and carry seeded with 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            count <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (load) begin
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= sub;
            count <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            s_sh  <= s_sh_next;
            carry <= carry_next;
            count <= count + CW'(1);
            if (last) begin
                sum  <= s_sh_next;
                cout <= carry_next;
`ifdef SERIAL_ADDER_OVF_EN
                // On the MSB step, carry holds the carry into the MSB.
                ovf  <= carry ^ carry_next;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder.
// Covers an 8-bit instance (reset, add, subtract, handshake, mid-op reset,
// optional overflow) and a 1-bit instance (half-adder truth table).
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;

    logic       start;
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start1;
    logic       sub1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf;
    logic       ovf1;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .sub   (sub1),
        .a     (a1),
        .b     (b1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf1)
`endif
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge, then settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete 8-bit operation with fixed latency: start at E0,
    // busy through E1..E7, done and result after E8.
    task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                          input logic isub, input logic [7:0] es, input logic ec,
                          input logic eo);
        a = ia; b = ib; sub = isub; start = 1'b1;
        step();
        start = 1'b0; a = 8'hA5; b = 8'h5A; sub = ~isub;
        check({tag, "_busy_e0"}, 64'(busy), 64'd1);
        for (int i = 1; i < 8; i++) begin
            step();
            check($sformatf("%s_busy_e%0d", tag, i), 64'({busy, done}), 64'b10);
        end
        step();
        check({tag, "_done"}, 64'({busy, done}), 64'b01);
        check({tag, "_sum"}, 64'(sum), 64'(es));
        check({tag, "_cout"}, 64'(cout), 64'(ec));
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"}, 64'(ovf), 64'(eo));
`else
        if (eo === 1'bx) $display("unused");
`endif
        step();
        check({tag, "_done_clr"}, 64'({busy, done}), 64'b00);
        check({tag, "_sum_hold"}, 64'(sum), 64'(es));
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; sub = 1'b0; a = 8'h33; b = 8'h44;
        start1 = 1'b1; sub1 = 1'b0; a1 = 1'b1; b1 = 1'b1;

        // Reset with start held high: reset wins.
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("rst_bd_%0d", i), 64'({busy, done}), 64'b00);
            check($sformatf("rst_sum_%0d", i), 64'(sum), 64'h00);
            check($sformatf("rst_cout_%0d", i), 64'(cout), 64'd0);
            check($sformatf("rst_w1_%0d", i), 64'({busy1, done1, sum1, cout1}), 64'b0000);
        end
        rst = 1'b0; start = 1'b0; start1 = 1'b0;
        step();
        check("idle_after_rst", 64'({busy, done}), 64'b00);

        // Addition and subtraction.
        run_op("add1", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        run_op("add2", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("sub1", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
        run_op("sub2", 8'h20, 8'h10, 1'b1, 8'h10, 1'b1, 1'b0);
        run_op("ovf1", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("ovf2", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        run_op("ovf3", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);

        // Handshake: start held high; operands change while busy.
        a = 8'h11; b = 8'h22; sub = 1'b0; start = 1'b1;
        step();
        for (int i = 1; i < 8; i++) begin
            a = 8'(i * 37); b = 8'(i * 91); sub = i[0];
            step();
            check($sformatf("hs1_busy_%0d", i), 64'({busy, done}), 64'b10);
        end
        step();
        check("hs1_done", 64'({busy, done}), 64'b01);
        check("hs1_sum", 64'(sum), 64'h33);
        check("hs1_cout", 64'(cout), 64'd0);
        a = 8'hC8; b = 8'h64; sub = 1'b1;
        step();
        check("hs2_capture", 64'({busy, done}), 64'b10);
        for (int i = 1; i < 8; i++) begin
            a = 8'(i * 13); b = 8'(i * 29); sub = ~i[0];
            step();
            check($sformatf("hs2_busy_%0d", i), 64'({busy, done}), 64'b10);
        end
        step();
        check("hs2_done", 64'({busy, done}), 64'b01);
        check("hs2_sum", 64'(sum), 64'h64);
        check("hs2_cout", 64'(cout), 64'd1);
`ifdef SERIAL_ADDER_OVF_EN
        check("hs2_ovf", 64'(ovf), 64'd1);
`endif
        start = 1'b0;
        step();
        check("hs_idle", 64'({busy, done}), 64'b00);

        // Reset during RUN: abort, no done, result cleared.
        a = 8'h5A; b = 8'h3C; sub = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i < 4; i++) step();
        check("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_bd", 64'({busy, done}), 64'b00);
        check("mid_rst_sum", 64'(sum), 64'h00);
        check("mid_rst_cout", 64'(cout), 64'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("mid_nodone_%0d", i), 64'({busy, done}), 64'b00);
        end
        run_op("post_rst", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

        // WIDTH=1: half-adder truth table, done one cycle after start.
        for (int v = 0; v < 4; v++) begin
            a1 = 1'(v >> 1); b1 = 1'(v); sub1 = 1'b0; start1 = 1'b1;
            step();
            start1 = 1'b0;
            check($sformatf("w1_busy_%0d", v), 64'({busy1, done1}), 64'b10);
            step();
            check($sformatf("w1_done_%0d", v), 64'({busy1, done1}), 64'b01);
            check($sformatf("w1_sum_%0d", v), 64'(sum1), 64'((v >> 1) ^ (v & 1)));
            check($sformatf("w1_cout_%0d", v), 64'(cout1), 64'((v >> 1) & (v & 1)));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised, bit-serial two's-complement adder/subtractor.
- Successor to the combinational half-adder cell: one sum bit per clock through a single full-adder slice plus a carry flip-flop.
- start/busy/done handshake; result held in an output register.
- Used where area matters more than latency. WIDTH=1 with sub=0 reproduces half-adder truth (sum=a^b, cout=a&b).

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..64.

Ports:
- clk, input, 1, single clock; all state changes on rising edge.
- rst, input, 1, synchronous, active-high reset.
- start, input, 1, request; sampled only when busy=0.
- sub, input, 1, 0 = a+b, 1 = a-b; captured with start.
- a, input, WIDTH, operand A; captured with start.
- b, input, WIDTH, operand B; captured with start.
- busy, output, 1, operation in progress.
- done, output, 1, one-cycle completion pulse.
- sum, output, WIDTH, result register.
- cout, output, 1, carry out of MSB. For sub: 1 = no borrow (a >= b unsigned).

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high.
- Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, sum=0, cout=0, bit counter=0, internal shift registers=0, carry FF=0.
- Reset during RUN aborts the operation. No done pulse; sum/cout cleared to 0.
- rst has priority over start.
- States: IDLE, RUN, DONE.
- IDLE: busy=0.
  - start=1 at an edge: load a_sh=a, b_sh=(sub ? ~b : b), carry=sub, count=0, go to RUN.
- RUN: busy=1. Each edge:
  - s = a_sh[0]^b_sh[0]^carry; carry <= majority(a_sh[0], b_sh[0], carry).
  - Shift a_sh and b_sh right by one; shift s into the MSB of s_sh; count+1.
  - On the edge where count == WIDTH-1: sum <= final s_sh (including s), cout <= final carry, go to DONE.
- DONE: busy=0, done=1 for exactly one cycle.
  - Next edge: go to IDLE, or to RUN if start=1 (back-to-back, new operands captured).
- Latency: start sampled at edge E0; bits processed on edges E1..EW; done=1 and sum/cout valid between EW and EW+1. WIDTH cycles start-to-done; throughput one op per WIDTH+1 cycles.
- start while busy=1 is ignored; operands are not re-captured.
- sum/cout hold their last result until the next completion or reset. Intermediate bits are never visible on sum.
- Width rules:
  - Arithmetic is modulo 2^WIDTH.
  - The counter is sized clog2(WIDTH), with a minimum of 1 bit.
  - WIDTH=1: RUN lasts a single edge.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit): signed overflow = carry into MSB XOR carry out of MSB.
  - Registered with sum; reset 0; held like sum.
  - For sub, computed on a + ~b + 1.
- Undefined: ovf port and its logic absent. No other behavioural difference.

Test Plan:
- Reset: drive rst=1 for 2 cycles with start=1 -> busy=0, done=0, sum=0x00, cout=0 throughout.
- Add: WIDTH=8, a=0x5A, b=0x3C, sub=0, start for 1 cycle -> busy=1 for 8 cycles, done pulses on the 8th cycle after start; sum=0x96, cout=0. Then a=0xFF, b=0x01 -> sum=0x00, cout=1.
- Subtract: a=0x10, b=0x20, sub=1 -> sum=0xF0, cout=0. Then a=0x20, b=0x10 -> sum=0x10, cout=1.
- Handshake: hold start=1 continuously with changing operands. Start during busy is ignored; a new op is captured in the DONE cycle; done pulses every 9 cycles. Each result matches the operands present on the capture edges.
- Reset mid-op: rst=1 at the 4th RUN cycle -> no done pulse, sum=0, state IDLE. A fresh op afterwards completes correctly.
- SERIAL_ADDER_OVF_EN, WIDTH=8: 0x7F+0x01 -> sum=0x80, ovf=1. 0x80-0x01 -> sum=0x7F, ovf=1. 0x05+0x03 -> ovf=0.
- WIDTH=1 sweep of the four a/b combos -> sum=a^b, cout=a&b, done 1 cycle after start.
